// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch stage.
// Owns the PC and drives a combinational instruction memory. Each fetched word is captured into
// the IF/ID register. In RUN the PC is sequenced under three controls, in this priority order:
// EX redirect, hazard stall, then normal +4 increment. A bad PC or bad redirect target stops
// fetching in HALT and raises a sticky error. Only reset exits HALT.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   imem_addr      instruction memory address (always the current PC)
//   imem_instr     instruction read from memory, valid in the same cycle
//   stall          hazard stall; holds the PC and IF/ID
//   redirect_valid taken branch/jump resolved in EX
//   redirect_pc    redirect target
//   if_id_instr    registered instruction
//   if_id_pc       PC of if_id_instr
//   if_id_valid    IF/ID holds a real instruction (0 = bubble)
//   fetch_err      sticky error, set on entering HALT
//   state_o        debug state: BOOT=0, RUN=1, HALT=2
//
// Optional build macro FETCH_PERF_EN adds three saturating counters:
//   perf_fetched, perf_stalls and perf_squashed.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       IMEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              fetch_err,
  output logic [1:0]        state_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalls,
  output logic [31:0]       perf_squashed
`endif
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  // First byte address past the end of instruction memory.
  localparam logic [ADDR_W-1:0] PcLimit = ADDR_W'(IMEM_DEPTH * 4);

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic [31:0]       r_instr, w_instr_next;
  logic [ADDR_W-1:0] r_if_pc, w_if_pc_next;
  logic              r_valid, w_valid_next;
  logic              r_err, w_err_next;

  logic w_redirect_bad;
  logic w_pc_bad;
  logic w_evt_fetch;
  logic w_evt_stall;
  logic w_evt_squash;

  assign w_redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PcLimit);
  assign w_pc_bad       = (r_pc[1:0] != 2'b00) || (r_pc >= PcLimit);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_if_pc_next = r_if_pc;
    w_valid_next = r_valid;
    w_err_next   = r_err;
    w_evt_fetch  = 1'b0;
    w_evt_stall  = 1'b0;
    w_evt_squash = 1'b0;
    case (r_state)
      StBoot: begin
        // One bubble cycle; stall and redirect are ignored here.
        w_state_next = StRun;
      end
      StRun: begin
        w_evt_stall = stall && !redirect_valid;
        if (redirect_valid) begin
          w_valid_next = 1'b0;
          if (w_redirect_bad) begin
            w_state_next = StHalt;
            w_err_next   = 1'b1;
          end else begin
            // Squash the wrong-path fetch; IF/ID instr/pc keep their old contents.
            w_pc_next    = redirect_pc;
            w_evt_squash = 1'b1;
          end
        end else if (w_pc_bad) begin
          // Range check beats stall: nothing is captured from an invalid PC.
          w_state_next = StHalt;
          w_err_next   = 1'b1;
          w_valid_next = 1'b0;
        end else if (!stall) begin
          w_instr_next = imem_instr;
          w_if_pc_next = r_pc;
          w_valid_next = 1'b1;
          w_pc_next    = r_pc + ADDR_W'(4);
          w_evt_fetch  = 1'b1;
        end
      end
      StHalt: begin
        w_valid_next = 1'b0;
        w_err_next   = 1'b1;
      end
      default: begin
        w_state_next = StHalt;
        w_valid_next = 1'b0;
        w_err_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StBoot;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_if_pc <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_if_pc <= w_if_pc_next;
      r_valid <= w_valid_next;
      r_err   <= w_err_next;
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_if_pc;
  assign if_id_valid = r_valid;
  assign fetch_err   = r_err;
  assign state_o     = r_state;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stalls, r_perf_squashed;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_fetched  <= '0;
      r_perf_stalls   <= '0;
      r_perf_squashed <= '0;
    end else begin
      if (w_evt_fetch && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_evt_stall && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 32'd1;
      if (w_evt_squash && (r_perf_squashed != '1)) r_perf_squashed <= r_perf_squashed + 32'd1;
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_stalls   = r_perf_stalls;
  assign perf_squashed = r_perf_squashed;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_evt_fetch ^ w_evt_stall ^ w_evt_squash;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random stall/redirect/reset
// traffic, checked each cycle against a cycle-level reference model of the fetch rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        fetch_err;
  logic [1:0]  state_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls, perf_squashed;
`endif

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  assign imem_instr = mem[imem_addr[5:2]];

  fetch_sequencer #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0),
    .IMEM_DEPTH(16)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .fetch_err     (fetch_err),
    .state_o       (state_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls),
    .perf_squashed (perf_squashed)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: 0=boot, 1=run, 2=halt. Memory ends at byte 64.
  int          m_state;
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid, m_err;
  logic [31:0] m_fetched, m_stalls, m_squashed;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_step(input bit rst_n_v, input bit st, input bit rv, input logic [31:0] rpc);
    if (!rst_n_v) begin
      m_state = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_err = 0;
      m_fetched = 0; m_stalls = 0; m_squashed = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (st && !rv) m_stalls = sat_inc(m_stalls);
      if (rv) begin
        m_valid = 0;
        if ((rpc % 4) != 0 || rpc >= 64) begin
          m_state = 2; m_err = 1;
        end else begin
          m_pc = rpc; m_squashed = sat_inc(m_squashed);
        end
      end else if (m_pc >= 64) begin
        m_state = 2; m_err = 1; m_valid = 0;
      end else if (!st) begin
        m_instr = mem[m_pc / 4];
        m_ifpc  = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 4;
        m_fetched = sat_inc(m_fetched);
      end
    end
  endtask

  task automatic step(input bit rst_n_v, input bit st, input bit rv, input logic [31:0] rpc);
    reset_n        = rst_n_v;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step(rst_n_v, st, rv, rpc);
    @(posedge clk);
    #1;
    check_val("imem_addr", imem_addr, m_pc);
    check_val("state", 32'(state_o), 32'(m_state));
    check_val("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check_val("if_id_pc", if_id_pc, m_ifpc);
    check_val("if_id_instr", if_id_instr, m_instr);
    check_val("fetch_err", 32'(fetch_err), 32'(m_err));
`ifdef FETCH_PERF_EN
    check_val("perf_fetched", perf_fetched, m_fetched);
    check_val("perf_stalls", perf_stalls, m_stalls);
    check_val("perf_squashed", perf_squashed, m_squashed);
`endif
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    bit          st, rv;
    logic [31:0] rpc;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Free run from reset through the whole memory into HALT.
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("run_end_err", 32'(fetch_err), 32'd1);
    check_val("run_end_pc", if_id_pc, 32'd60);
    step(1'b1, 1'b0, 1'b1, 32'd8);
    step(1'b1, 1'b1, 1'b0, 32'd0);

    // Stall for three cycles with pc=8.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check_val("stall_addr", imem_addr, 32'd8);
    check_val("stall_ifpc", if_id_pc, 32'd4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("stall_after", if_id_pc, 32'd12);

    // Redirect wins over a simultaneous stall at pc=20.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'd40);
    check_val("redir_pc", imem_addr, 32'd40);
    check_val("redir_valid", 32'(if_id_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("redir_ifpc", if_id_pc, 32'd40);

    // Bad redirects: misaligned, then out of range.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'd42);
    step(1'b1, 1'b0, 1'b1, 32'd8);
    check_val("bad42_state", 32'(state_o), 32'd2);
    do_reset();
    check_val("recover_pc", imem_addr, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'd64);
    check_val("bad64_err", 32'(fetch_err), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'd4);

    // Reset mid-stream at pc=28.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("mid_pc", imem_addr, 32'd28);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("mid_rst_instr", if_id_instr, 32'd0);

    // 5 fetches, 2 stall cycles, 1 redirect.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'd0);
`ifdef FETCH_PERF_EN
    check_val("perf5", perf_fetched, 32'd5);
    check_val("perf2", perf_stalls, 32'd2);
    check_val("perf1", perf_squashed, 32'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if (($urandom_range(0, 99) < 2) || (m_state == 2 && $urandom_range(0, 99) < 25)) begin
        step(1'b0, 1'(($urandom & 1)), 1'(($urandom & 1)), $urandom);
      end else begin
        st = ($urandom_range(0, 99) < 25);
        rv = ($urandom_range(0, 99) < 15);
        if ($urandom_range(0, 99) < 80) rpc = 32'($urandom_range(0, 15)) << 2;
        else if ($urandom & 1) rpc = 32'($urandom_range(0, 63)) | 32'd1;
        else rpc = 32'($urandom_range(64, 1000)) & ~32'd3;
        step(1'b1, st, rv, rpc);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
